// File: rtl/pipe_exec_ctrl_pkg.sv
// Shared command codes, state encodings and width helpers for the pipeline
// execution controller and the debug unit that drives it.
package pipe_exec_ctrl_pkg;

  localparam int CMD_W   = 3;
  localparam int STATE_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 3'd0,
    CMD_RUN   = 3'd1,
    CMD_STEP  = 3'd2,
    CMD_RUN_N = 3'd3,
    CMD_STOP  = 3'd4,
    CMD_CLR   = 3'd5
  } cmd_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_COUNT  = 3'd2,
    ST_HALTED = 3'd3
  } state_e;

  // A single breakpoint channel still gets a 1-bit index port.
  function automatic int brk_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_exec_ctrl_brk_match.sv
// Breakpoint table with PC comparators, lowest-index priority encoder and the
// sticky hit/id registers reported to the debug unit.
module pipe_exec_ctrl_brk_match
  import pipe_exec_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int N_BRK  = 4,
  localparam int IDX_W = brk_idx_w(N_BRK)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_cmp_en,
  input  logic              i_set_hit,
  input  logic              i_clr_hit,
  output logic              o_match,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_id
);

  logic [ADDR_W-1:0] tbl_addr_q [N_BRK];
  logic [N_BRK-1:0]  tbl_en_q;
  logic              hit_q;
  logic [IDX_W-1:0]  id_q;
  logic [IDX_W-1:0]  match_id;

  // Index values with no matching entry (non power-of-two tables) fall through.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_BRK; i++) begin
        tbl_addr_q[i] <= '0;
      end
      tbl_en_q <= '0;
    end else begin
      for (int i = 0; i < N_BRK; i++) begin
        if (i_wr && (i_idx == IDX_W'(i))) begin
          tbl_addr_q[i] <= i_addr;
          tbl_en_q[i]   <= i_en;
        end
      end
    end
  end

  // Scanning downward leaves the lowest matching index in match_id.
  always_comb begin
    o_match  = 1'b0;
    match_id = '0;
    for (int i = N_BRK - 1; i >= 0; i--) begin
      if (i_cmp_en && tbl_en_q[i] && (tbl_addr_q[i] == i_pc)) begin
        o_match  = 1'b1;
        match_id = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      hit_q <= 1'b0;
      id_q  <= '0;
    end else if (i_clr_hit) begin
      hit_q <= 1'b0;
      id_q  <= '0;
    end else if (i_set_hit) begin
      hit_q <= 1'b1;
      id_q  <= match_id;
    end
  end

  assign o_hit = hit_q;
  assign o_id  = id_q;

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Pipeline execution controller: turns debug-unit commands, breakpoints and
// HALT retirement into the global pipe enable, plus a saturating cycle counter.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | pipe frozen, accepts RUN/STEP/RUN_N/CLR
//   ST_RUN    | free running until STOP, breakpoint or halt
//   ST_COUNT  | running for remain_q more enabled cycles
//   ST_HALTED | HALT retired, only CLR leaves this state
module pipe_exec_ctrl
  import pipe_exec_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int N_BRK    = 4,
  parameter int NB_COUNT = 32,
  parameter int STEP_W   = 16,
  localparam int IDX_W   = brk_idx_w(N_BRK)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [CMD_W-1:0]    i_cmd,
  input  logic [STEP_W-1:0]   i_cmd_arg,
  input  logic                i_brk_wr,
  input  logic [IDX_W-1:0]    i_brk_idx,
  input  logic [ADDR_W-1:0]   i_brk_addr,
  input  logic                i_brk_en,
  input  logic [ADDR_W-1:0]   i_pc_fetch,
  input  logic                i_halt_retired,
  output logic                o_enable_pipe,
  output logic [STATE_W-1:0]  o_state,
  output logic [NB_COUNT-1:0] o_count_cycles,
  output logic                o_brk_hit,
  output logic [IDX_W-1:0]    o_brk_id,
  output logic                o_done,
  output logic                o_cmd_err
);

  state_e              state_q, state_d;
  logic                enable_q, enable_d;
  logic                en_prev_q;
  logic [STEP_W-1:0]   remain_q, remain_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CMD_W-1:0]    cmd;
  logic                cmp_en;
  logic                brk_match;
  logic                brk_set;
  logic                brk_clr;

  // Compare is suppressed on the first enabled cycle so a resume from a
  // breakpoint stop does not immediately stop again on the same PC.
  assign cmp_en = enable_q && en_prev_q;
  assign cmd    = i_cmd_valid ? i_cmd : CMD_NOP;

  pipe_exec_ctrl_brk_match #(
    .ADDR_W (ADDR_W),
    .N_BRK  (N_BRK)
  ) u_brk_match (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_wr      (i_brk_wr),
    .i_idx     (i_brk_idx),
    .i_addr    (i_brk_addr),
    .i_en      (i_brk_en),
    .i_pc      (i_pc_fetch),
    .i_cmp_en  (cmp_en),
    .i_set_hit (brk_set),
    .i_clr_hit (brk_clr),
    .o_match   (brk_match),
    .o_hit     (o_brk_hit),
    .o_id      (o_brk_id)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      enable_q  <= 1'b0;
      en_prev_q <= 1'b0;
      remain_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      en_prev_q <= enable_q;
      remain_q  <= remain_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    count_d  = count_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    brk_set  = 1'b0;
    brk_clr  = 1'b0;

    if (enable_q && (count_q != '1)) begin
      count_d = count_q + NB_COUNT'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        unique case (cmd)
          CMD_NOP, CMD_STOP: ;
          CMD_RUN: state_d = ST_RUN;
          CMD_STEP: begin
            state_d  = ST_COUNT;
            remain_d = STEP_W'(1);
          end
          CMD_RUN_N: begin
            if (i_cmd_arg == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = ST_COUNT;
              remain_d = i_cmd_arg;
            end
          end
          CMD_CLR: begin
            count_d = '0;
            brk_clr = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end

      ST_RUN, ST_COUNT: begin
        if (state_q == ST_COUNT) begin
          remain_d = remain_q - STEP_W'(1);
        end
        if ((cmd != CMD_NOP) && (cmd != CMD_STOP)) begin
          err_d = 1'b1;
        end
        // Stop sources in priority order: halt, STOP, breakpoint, expiry.
        if (i_halt_retired) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (cmd == CMD_STOP) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (brk_match) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          brk_set = 1'b1;
        end else if ((state_q == ST_COUNT) && (remain_q == STEP_W'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_HALTED: begin
        if (cmd == CMD_CLR) begin
          state_d = ST_IDLE;
          count_d = '0;
          brk_clr = 1'b1;
        end else if (cmd != CMD_NOP) begin
          err_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    enable_d = (state_d == ST_RUN) || (state_d == ST_COUNT);
  end

  assign o_enable_pipe  = enable_q;
  assign o_state        = state_q;
  assign o_count_cycles = count_q;
  assign o_done         = done_q;
  assign o_cmd_err      = err_q;

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Directed bench for pipe_exec_ctrl: a default-width instance plus a 4-bit
// counter instance sharing the same stimulus.
module tb_pipe_exec_ctrl;
  import pipe_exec_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [15:0] cmd_arg;
  logic        brk_wr;
  logic [1:0]  brk_idx;
  logic [31:0] brk_addr;
  logic        brk_en;
  logic [31:0] pc;
  logic        halt;

  logic        en_pipe, brk_hit, done, cmd_err;
  logic [2:0]  state;
  logic [31:0] count;
  logic [1:0]  brk_id;

  logic        s_en_pipe, s_brk_hit, s_done, s_cmd_err;
  logic [2:0]  s_state;
  logic [3:0]  s_count;
  logic [1:0]  s_brk_id;

  int total = 0;
  int bad   = 0;

  pipe_exec_ctrl dut (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_cmd_arg(cmd_arg), .i_brk_wr(brk_wr), .i_brk_idx(brk_idx),
    .i_brk_addr(brk_addr), .i_brk_en(brk_en), .i_pc_fetch(pc),
    .i_halt_retired(halt), .o_enable_pipe(en_pipe), .o_state(state),
    .o_count_cycles(count), .o_brk_hit(brk_hit), .o_brk_id(brk_id),
    .o_done(done), .o_cmd_err(cmd_err)
  );

  pipe_exec_ctrl #(.NB_COUNT(4)) dut_small (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_cmd_arg(cmd_arg), .i_brk_wr(brk_wr), .i_brk_idx(brk_idx),
    .i_brk_addr(brk_addr), .i_brk_en(brk_en), .i_pc_fetch(pc),
    .i_halt_retired(halt), .o_enable_pipe(s_en_pipe), .o_state(s_state),
    .o_count_cycles(s_count), .o_brk_hit(s_brk_hit), .o_brk_id(s_brk_id),
    .o_done(s_done), .o_cmd_err(s_cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [15:0] a);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_arg   = a;
    tick(1);
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    cmd_arg   = '0;
  endtask

  task automatic brk_write(input logic [1:0] idx, input logic [31:0] addr, input logic en);
    brk_wr   = 1'b1;
    brk_idx  = idx;
    brk_addr = addr;
    brk_en   = en;
    tick(1);
    brk_wr   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP; cmd_arg = '0;
    brk_wr = 1'b0; brk_idx = '0; brk_addr = '0; brk_en = 1'b0;
    pc = 32'h100; halt = 1'b0;
    tick(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_enable", 32'(en_pipe), 0);
    chk("rst_count", count, 0);
    chk("rst_hit", 32'(brk_hit), 0);
    chk("rst_done_err", {30'd0, done, cmd_err}, 0);
    rst_n = 1'b1;
    tick(1);

    // Free run for 10 enabled cycles then STOP
    send(CMD_RUN, 0);
    chk("run_state", 32'(state), 1);
    chk("run_enable", 32'(en_pipe), 1);
    tick(9);
    chk("run_count9", count, 9);
    send(CMD_STOP, 0);
    chk("stop_state", 32'(state), 0);
    chk("stop_enable", 32'(en_pipe), 0);
    chk("stop_count", count, 10);
    chk("stop_done", 32'(done), 1);
    tick(1);
    chk("stop_done_pulse", 32'(done), 0);

    // Single steps
    send(CMD_CLR, 0);
    chk("clr_count", count, 0);
    for (int i = 0; i < 3; i++) begin
      send(CMD_STEP, 0);
      chk("step_enable_on", 32'(en_pipe), 1);
      chk("step_state", 32'(state), 2);
      tick(1);
      chk("step_enable_off", 32'(en_pipe), 0);
      chk("step_done", 32'(done), 1);
    end
    chk("step_count", count, 3);
    send(CMD_RUN_N, 0);
    chk("runn0_state", 32'(state), 0);
    chk("runn0_enable", 32'(en_pipe), 0);
    chk("runn0_done", 32'(done), 1);
    chk("runn0_count", count, 3);

    // RUN_N 5 with an illegal CLR mid-count
    send(CMD_RUN_N, 5);
    send(CMD_CLR, 0);
    chk("count_clr_err", 32'(cmd_err), 1);
    chk("count_clr_state", 32'(state), 2);
    chk("count_clr_count", count, 4);
    tick(3);
    chk("runn5_still_on", 32'(en_pipe), 1);
    chk("runn5_err_pulse", 32'(cmd_err), 0);
    tick(1);
    chk("runn5_off", 32'(en_pipe), 0);
    chk("runn5_done", 32'(done), 1);
    chk("runn5_count", count, 8);

    // Breakpoints: entries 2 and 0 both at 0x20
    pc = 32'h10;
    brk_write(2'd2, 32'h20, 1'b1);
    brk_write(2'd0, 32'h20, 1'b1);
    send(CMD_RUN, 0);
    tick(2);
    chk("bp_pre_state", 32'(state), 1);
    pc = 32'h20;
    tick(1);
    chk("bp_state", 32'(state), 0);
    chk("bp_enable", 32'(en_pipe), 0);
    chk("bp_hit", 32'(brk_hit), 1);
    chk("bp_id_lowest", 32'(brk_id), 0);
    chk("bp_done", 32'(done), 1);
    send(CMD_RUN, 0);
    tick(1);
    chk("bp_no_rehit", 32'(state), 1);
    pc = 32'h24;
    tick(2);
    chk("bp_running", 32'(state), 1);
    send(CMD_STOP, 0);
    brk_write(2'd0, 32'h20, 1'b0);
    send(CMD_RUN, 0);
    tick(1);
    pc = 32'h20;
    tick(1);
    chk("bp2_state", 32'(state), 0);
    chk("bp2_id", 32'(brk_id), 2);

    // Halt during RUN_N 100 at the 40th enabled cycle
    pc = 32'h200;
    send(CMD_CLR, 0);
    chk("clr_hit", 32'(brk_hit), 0);
    chk("clr_id", 32'(brk_id), 0);
    send(CMD_RUN_N, 100);
    tick(39);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("halt_state", 32'(state), 3);
    chk("halt_enable", 32'(en_pipe), 0);
    chk("halt_count", count, 40);
    chk("halt_done", 32'(done), 1);
    tick(1);
    chk("halt_count_hold", count, 40);
    send(CMD_RUN, 0);
    chk("halted_run_err", 32'(cmd_err), 1);
    chk("halted_run_state", 32'(state), 3);
    send(CMD_CLR, 0);
    chk("halted_clr_state", 32'(state), 0);
    chk("halted_clr_count", count, 0);
    chk("halted_clr_err", 32'(cmd_err), 0);

    // Halt + breakpoint + STOP together
    send(CMD_RUN, 0);
    tick(1);
    pc = 32'h20;
    halt = 1'b1;
    send(CMD_STOP, 0);
    halt = 1'b0;
    pc = 32'h200;
    chk("prio_halt_state", 32'(state), 3);
    chk("prio_halt_hit", 32'(brk_hit), 0);
    chk("prio_halt_done", 32'(done), 1);
    tick(1);
    chk("prio_single_done", 32'(done), 0);
    send(CMD_CLR, 0);

    // STOP beats breakpoint
    send(CMD_RUN, 0);
    tick(1);
    pc = 32'h20;
    send(CMD_STOP, 0);
    chk("prio_stop_state", 32'(state), 0);
    chk("prio_stop_hit", 32'(brk_hit), 0);

    // Breakpoint beats count expiry
    send(CMD_RUN_N, 2);
    tick(1);
    chk("prio_exp_mid", 32'(state), 2);
    tick(1);
    chk("prio_exp_state", 32'(state), 0);
    chk("prio_exp_hit", 32'(brk_hit), 1);
    chk("prio_exp_id", 32'(brk_id), 2);
    chk("prio_exp_done", 32'(done), 1);

    // 4-bit counter saturation, then async reset mid-run
    pc = 32'h100;
    brk_write(2'd1, 32'h40, 1'b1);
    send(CMD_CLR, 0);
    chk("small_clr", 32'(s_count), 0);
    send(CMD_RUN, 0);
    tick(20);
    chk("small_sat", 32'(s_count), 15);
    chk("big_count20", count, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_enable", 32'(en_pipe), 0);
    chk("async_rst_small_en", 32'(s_en_pipe), 0);
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_count", count, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    send(CMD_RUN, 0);
    tick(1);
    pc = 32'h40;
    tick(2);
    pc = 32'h20;
    tick(2);
    chk("tbl_cleared_state", 32'(state), 1);
    chk("tbl_cleared_hit", 32'(brk_hit), 0);
    send(CMD_STOP, 0);
    chk("final_done", 32'(done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
